// File: rtl/pulsegen.sv
// -----------------------------------------------------------------------------
// pulsegen -- programmable PWM pulse generator
//
// Produces a registered pulse train. Each period lasts period_a clock cycles.
// The output is high for the first width_a cycles of the period and low for
// the rest. Runtime reconfiguration takes effect only on a period boundary, so
// a period that is already running always completes unchanged.
//
// Parameters
//   CLK_FREQ_HZ : clock frequency in Hz (informational only)
//   PERIOD_DEF  : period in cycles after reset (must be nonzero)
//   WIDTH_DEF   : high width in cycles after reset
//
// Ports
//   clk          : clock, rising edge
//   aresetn      : asynchronous reset, active HIGH despite the name
//   start        : run enable; 0 holds the output low and rewinds the period
//   config_valid : one-cycle strobe qualifying period_in / width_in
//   period_in    : requested period in cycles (0 = request ignored)
//   width_in     : requested high width in cycles (>= period gives constant high)
//   pulse_out    : registered PWM output
// -----------------------------------------------------------------------------
module pulsegen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PERIOD_DEF  = 1000,
    parameter int unsigned WIDTH_DEF   = 500
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        config_valid,
    input  logic [31:0] period_in,
    input  logic [31:0] width_in,
    output logic        pulse_out
);

    // A zero period would make the wrap test underflow.
    if (PERIOD_DEF == 0 || CLK_FREQ_HZ == 0) begin : g_bad_param
        $error("pulsegen: PERIOD_DEF and CLK_FREQ_HZ must be nonzero");
    end

    localparam logic [31:0] PERIOD_RST = 32'(PERIOD_DEF);
    localparam logic [31:0] WIDTH_RST  = 32'(WIDTH_DEF);

    // Active configuration, governs the period in progress.
    logic [31:0] period_a;
    logic [31:0] width_a;
    // Pending configuration, waiting for the next period boundary.
    logic [31:0] period_p;
    logic [31:0] width_p;
    logic        pend;
    logic [31:0] cnt;

    logic [31:0] period_a_next;
    logic [31:0] width_a_next;
    logic [31:0] period_p_next;
    logic [31:0] width_p_next;
    logic        pend_next;
    logic [31:0] cnt_next;
    logic        pulse_next;

    logic        accept;
    logic        wrap;

    // A zero period can never be active, so period_in = 0 is dropped here.
    assign accept = config_valid && (period_in != 32'd0);
    // period_a is never zero, so period_a - 1 cannot underflow.
    assign wrap   = (cnt >= period_a - 32'd1);

    always_comb begin
        period_a_next = period_a;
        width_a_next  = width_a;
        period_p_next = period_p;
        width_p_next  = width_p;
        pend_next     = pend;
        cnt_next      = cnt;
        pulse_next    = 1'b0;

        if (start) begin
            // cnt never exceeds period_a - 1, so width_a >= period_a keeps
            // the output high throughout and width_a = 0 keeps it low.
            pulse_next = (cnt < width_a);
            cnt_next   = wrap ? 32'd0 : cnt + 32'd1;

            // The boundary swap uses the old pending values; a request on the
            // same edge is queued afterwards for the following boundary.
            if (wrap && pend) begin
                period_a_next = period_p;
                width_a_next  = width_p;
                pend_next     = 1'b0;
            end
            if (accept) begin
                period_p_next = period_in;
                width_p_next  = width_in;
                pend_next     = 1'b1;
            end
        end else begin
            cnt_next = 32'd0;
            // Idle: no period in progress, so configuration applies at once.
            if (accept) begin
                period_a_next = period_in;
                width_a_next  = width_in;
                pend_next     = 1'b0;
            end else if (pend) begin
                period_a_next = period_p;
                width_a_next  = width_p;
                pend_next     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            period_a  <= PERIOD_RST;
            width_a   <= WIDTH_RST;
            period_p  <= PERIOD_RST;
            width_p   <= WIDTH_RST;
            pend      <= 1'b0;
            cnt       <= 32'd0;
            pulse_out <= 1'b0;
        end else begin
            period_a  <= period_a_next;
            width_a   <= width_a_next;
            period_p  <= period_p_next;
            width_p   <= width_p_next;
            pend      <= pend_next;
            cnt       <= cnt_next;
            pulse_out <= pulse_next;
        end
    end

endmodule

// File: tb/tb_pulsegen.sv
// -----------------------------------------------------------------------------
// tb_pulsegen -- scoreboard bench for pulsegen
//
// The driver applies one set of inputs per cycle on the falling edge. For each
// cycle it asks a waveform-level reference model for the pulse_out value
// expected after the next rising edge and queues it. A separate monitor pops
// one expectation per rising edge and compares.
//
// The model does not count cycles. At each period start it builds the whole
// period as a queue of output bits: min(width, period) ones, then zeros. Every
// running cycle consumes one bit. The period boundary is the cycle that
// consumes the final bit.
// -----------------------------------------------------------------------------
module tb_pulsegen;

    localparam int unsigned P_DEF = 100;
    localparam int unsigned W_DEF = 50;

    logic        clk          = 1'b0;
    logic        aresetn      = 1'b1;
    logic        start        = 1'b0;
    logic        config_valid = 1'b0;
    logic [31:0] period_in    = 32'd0;
    logic [31:0] width_in     = 32'd0;
    logic        pulse_out;

    pulsegen #(
        .CLK_FREQ_HZ (100_000_000),
        .PERIOD_DEF  (P_DEF),
        .WIDTH_DEF   (W_DEF)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .start        (start),
        .config_valid (config_valid),
        .period_in    (period_in),
        .width_in     (width_in),
        .pulse_out    (pulse_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit exp_q[$];

    // Reference model state
    int unsigned m_ap = P_DEF, m_aw = W_DEF;   // active period / width
    int unsigned m_pp = P_DEF, m_pw = W_DEF;   // queued request
    bit          m_pend = 1'b0;
    bit          wave[$];                      // remaining bits of current period
    bit          prev_r = 1'b0;

    function automatic bit model_step(input bit r, input bit s, input bit cv,
                                      input logic [31:0] p, input logic [31:0] w);
        bit          e;
        bit          acc;
        int unsigned hi;
        if (r) begin
            m_ap = P_DEF; m_aw = W_DEF; m_pp = P_DEF; m_pw = W_DEF;
            m_pend = 1'b0;
            wave.delete();
            return 1'b0;
        end
        acc = cv && (p != 0);
        if (s) begin
            if (wave.size() == 0) begin
                hi = (m_aw < m_ap) ? m_aw : m_ap;
                repeat (hi) wave.push_back(1'b1);
                repeat (m_ap - hi) wave.push_back(1'b0);
            end
            e = wave.pop_front();
            if (wave.size() == 0 && m_pend) begin
                m_ap = m_pp; m_aw = m_pw; m_pend = 1'b0;
            end
            if (acc) begin
                m_pp = p; m_pw = w; m_pend = 1'b1;
            end
        end else begin
            e = 1'b0;
            wave.delete();
            if (acc) begin
                m_ap = p; m_aw = w; m_pend = 1'b0;
            end else if (m_pend) begin
                m_ap = m_pp; m_aw = m_pw; m_pend = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic cyc(input bit r, input bit s, input bit cv,
                       input logic [31:0] p, input logic [31:0] w);
        bit e;
        @(negedge clk);
        aresetn      = r;
        start        = s;
        config_valid = cv;
        period_in    = p;
        width_in     = w;
        e = model_step(r, s, cv, p, w);
        exp_q.push_back(e);
        if (r && !prev_r) begin
            // Reset is asynchronous: the output must already be low.
            #1;
            n_chk++;
            if (pulse_out !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset t=%0t: pulse_out=%b, required 0", $time, pulse_out);
            end
        end
        prev_r = r;
    endtask

    task automatic run(input int n, input bit s);
        repeat (n) cyc(1'b0, s, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic cfg(input bit s, input logic [31:0] p, input logic [31:0] w);
        cyc(1'b0, s, 1'b1, p, w);
    endtask

    task automatic rst(input int n, input bit s);
        repeat (n) cyc(1'b1, s, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: one output per rising edge, compared against the queue
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (pulse_out !== e) begin
                    n_fail++;
                    $display("FAIL pulse_out t=%0t: got %b, required %b", $time, pulse_out, e);
                end
            end
        end
    end

    initial begin
        int          k;
        bit          r, s, cv;
        logic [31:0] p, w;

        // Reset, then defaults 100/50
        rst(3, 1'b0);
        run(250, 1'b1);

        // Reconfigure to 40/10 mid-period; current period must finish first
        cfg(1'b1, 32'd40, 32'd10);
        run(300, 1'b1);

        // Stop and restart
        run(6, 1'b0);
        run(90, 1'b1);

        // Reset restore, back to defaults, then 60/30
        rst(10, 1'b1);
        run(220, 1'b1);
        cfg(1'b1, 32'd60, 32'd30);
        run(250, 1'b1);

        // Edge configurations: zero period ignored, width = period, width = 0
        cfg(1'b1, 32'd0, 32'd7);
        run(150, 1'b1);
        cfg(1'b1, 32'd20, 32'd20);
        run(150, 1'b1);
        cfg(1'b1, 32'd30, 32'd0);
        run(100, 1'b1);

        // Idle load
        run(3, 1'b0);
        cfg(1'b0, 32'd40, 32'd10);
        run(2, 1'b0);
        run(120, 1'b1);

        // Last write wins, then stop while a request is pending
        cfg(1'b1, 32'd50, 32'd5);
        cfg(1'b1, 32'd70, 32'd35);
        run(10, 1'b1);
        cfg(1'b1, 32'd25, 32'd5);
        run(4, 1'b1);
        run(3, 1'b0);
        run(100, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 999) < 3);
            s  = ($urandom_range(0, 99) < 93);
            cv = ($urandom_range(0, 99) < 5);
            p  = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
            w  = 32'($urandom_range(0, p + 5));
            cyc(r, s, cv, p, w);
        end

        // Drain the scoreboard, bounded
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk);
            #2;
            k++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulsegen.md
PULSEGEN -- requirements
Module: pulsegen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000: clock frequency in Hz, informational only, not used in any arithmetic.
REQ-002 The block SHALL have parameter PERIOD_DEF, default 1000: reset-value period in clock cycles.
REQ-003 The block SHALL have parameter WIDTH_DEF, default 500: reset-value high width in clock cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-high reset (asserted at 1, despite the name).
REQ-006 The block SHALL have port start, input, 1 bit: run enable; 0 forces the output low.
REQ-007 The block SHALL have port config_valid, input, 1 bit: single-cycle strobe qualifying period_in and width_in.
REQ-008 The block SHALL have port period_in, input, 32 bits: requested period in cycles.
REQ-009 The block SHALL have port width_in, input, 32 bits: requested high width in cycles.
REQ-010 The block SHALL have port pulse_out, output, 1 bit: registered PWM output.

Function
REQ-011 The block SHALL hold active registers period_a and width_a (32 bits each), pending registers period_p and width_p, a pend flag, and a 32-bit counter cnt.
REQ-012 On each rising edge with start=1, the block SHALL set pulse_out <= (cnt < width_a) and advance cnt (cnt+1, or 0 when cnt >= period_a-1).
REQ-013 The comparison of REQ-012 SHALL give pulse_out high for width_a cycles, then low for period_a-width_a cycles, repeating; the first high cycle SHALL start at the first edge where start is sampled 1.
REQ-014 The block SHALL drive pulse_out constantly high while start=1 when width_a >= period_a, and constantly low when width_a = 0.
REQ-015 On each rising edge with start=0, the block SHALL set pulse_out <= 0 and cnt <= 0, so a later restart begins a fresh period.
REQ-016 The block SHALL ignore config_valid=1 when period_in = 0, leaving all state unchanged.
REQ-017 On an accepted config_valid with start=0, the block SHALL load period_a/width_a directly from period_in/width_in on that edge and clear pend.
REQ-018 On an accepted config_valid with start=1, the block SHALL capture the inputs into period_p/width_p and set pend; active values SHALL NOT change mid-period.
REQ-019 At the edge where cnt wraps to 0 with pend=1, the block SHALL copy period_p/width_p into period_a/width_a and clear pend; the new values SHALL govern the period starting at cnt=0.
REQ-020 The block SHALL let a later accepted config_valid overwrite the pending values (last write wins).
REQ-021 If config_valid arrives on the same edge as a wrap, the block SHALL perform the wrap with the old pending contents, then store the new request as pending.
REQ-022 If start falls while pend=1, the block SHALL load the pending values into the active registers on that edge and clear pend.
REQ-023 The block SHALL treat period_in and width_in as unsigned 32-bit values, with no saturation beyond REQ-014.

Reset
REQ-024 While aresetn=1, the block SHALL asynchronously force pulse_out=0, cnt=0, period_a=PERIOD_DEF, width_a=WIDTH_DEF, pend=0, and period_p/width_p to the defaults.
REQ-025 After aresetn deasserts, the block SHALL resume operation on the first rising edge; a reset mid-period SHALL discard any pending configuration.

Verification
REQ-026 A bench SHALL cover defaults: PERIOD_DEF=100, WIDTH_DEF=50, reset, start=1 -> pulse_out 50 cycles high, 50 low, repeating; first high on the first edge with start=1.
REQ-027 A bench SHALL cover reconfiguration: running at 100/50, one-cycle config_valid with period_in=40, width_in=10 -> current 100-cycle period completes unchanged, then 10 high / 30 low.
REQ-028 A bench SHALL cover stop and restart: start=0 -> pulse_out 0 from the next edge; start=1 again -> a full width_a-high period starts from cnt=0.
REQ-029 A bench SHALL cover reset restore: after running at 40/10, assert aresetn=1 for 10 cycles -> pulse_out 0 immediately; after release, 100/50 again; then config 60/30 -> 30 high / 30 low after the boundary.
REQ-030 A bench SHALL cover edge configurations: config period_in=0 -> ignored; width_in=20, period_in=20 -> constant high; width_in=0 -> constant low.
REQ-031 A bench SHALL cover idle load: config 40/10 applied while start=0 -> first period after start=1 is already 10 high / 30 low.
